// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with an all-off guard gap between digits.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.

module seg_hex7 (
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg_n
);
   // Active-low, bit order {g,f,e,d,c,b,a}
   always_comb begin
      case (i_hex)
         4'h0:    o_seg_n = 7'h40;
         4'h1:    o_seg_n = 7'h79;
         4'h2:    o_seg_n = 7'h24;
         4'h3:    o_seg_n = 7'h30;
         4'h4:    o_seg_n = 7'h19;
         4'h5:    o_seg_n = 7'h12;
         4'h6:    o_seg_n = 7'h02;
         4'h7:    o_seg_n = 7'h78;
         4'h8:    o_seg_n = 7'h00;
         4'h9:    o_seg_n = 7'h10;
         4'hA:    o_seg_n = 7'h08;
         4'hB:    o_seg_n = 7'h03;
         4'hC:    o_seg_n = 7'h46;
         4'hD:    o_seg_n = 7'h21;
         4'hE:    o_seg_n = 7'h06;
         default: o_seg_n = 7'h0E;
      endcase
   end
endmodule

module seg_scan_ctrl #(
   parameter  int NUM_DIGITS   = 4,
   parameter  int REFRESH_DIV  = 50000,
   parameter  int GUARD_CYCLES = 2,
   parameter  int BLINK_FRAMES = 64,
   localparam int LP_IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [LP_IDX_W-1:0]   wr_digit,
   input  logic [3:0]            wr_data,
   input  logic                  wr_blank,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] an_n
);
   localparam int LP_CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int LP_CNT_W   = (LP_CNT_MAX > 1) ? $clog2(LP_CNT_MAX) : 1;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 1 || GUARD_CYCLES < 1 ||
       BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_scan_ctrl: parameter out of range");
   end

   typedef enum logic {ST_GUARD = 1'b0, ST_DRIVE = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [LP_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [LP_IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [3:0]            r_val [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_blk;
   logic [6:0]            r_seg_n, w_seg_nxt;
   logic [NUM_DIGITS-1:0] r_an_n, w_an_nxt;
   logic                  w_wr_fire;
   logic [3:0]            w_drv_val;
   logic                  w_drv_blk;
   logic [6:0]            w_dec_seg_n;
   logic                  w_blink_off;

   // Write handshake: a write happens on a clk edge where wr_valid && wr_ready;
   // wr_ready is high exactly while the scanner sits in the guard gap.
   assign wr_ready  = (r_state == ST_GUARD);
   assign w_wr_fire = wr_valid && wr_ready;
   assign seg_n     = r_seg_n;
   assign an_n      = r_an_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_val[i] <= 4'h0;
         r_blk <= '1;
      end else if (w_wr_fire) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_digit == LP_IDX_W'(i)) begin
               r_val[i] <= wr_data;
               r_blk[i] <= wr_blank;
            end
         end
      end
   end

   // A write landing on the guard->drive edge for the digit about to be shown is forwarded.
   always_comb begin
      w_drv_val = r_val[r_idx];
      w_drv_blk = r_blk[r_idx];
      if (w_wr_fire && (wr_digit == r_idx)) begin
         w_drv_val = wr_data;
         w_drv_blk = wr_blank;
      end
   end

   seg_hex7 u_hex7 (
      .i_hex   (w_drv_val),
      .o_seg_n (w_dec_seg_n)
   );

`ifdef SEG_BLINK_EN
   localparam int LP_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [LP_FRM_W-1:0] r_frm_cnt;
   logic                r_blink_phase;
   logic                w_frame_done;

   // Frame boundary is where idx wraps back to 0; the new phase is first seen by digit 0's drive.
   assign w_frame_done = (r_state == ST_DRIVE) && (r_cnt == LP_CNT_W'(REFRESH_DIV - 1)) &&
                         (r_idx == LP_IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frm_cnt     <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_frame_done) begin
         if (r_frm_cnt == LP_FRM_W'(BLINK_FRAMES - 1)) begin
            r_frm_cnt     <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_frm_cnt <= r_frm_cnt + 1'b1;
         end
      end
   end

   assign w_blink_off = r_blink_phase && blink_mask[r_idx];
`else
   assign w_blink_off = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_GUARD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_seg_n <= 7'h7F;
         r_an_n  <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_seg_n <= w_seg_nxt;
         r_an_n  <= w_an_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_seg_nxt   = r_seg_n;
      w_an_nxt    = r_an_n;
      case (r_state)
         ST_GUARD: begin
            if (r_cnt == LP_CNT_W'(GUARD_CYCLES - 1)) begin
               w_state_nxt     = ST_DRIVE;
               w_cnt_nxt       = '0;
               w_an_nxt        = '1;
               w_an_nxt[r_idx] = 1'b0;
               w_seg_nxt       = (w_drv_blk || w_blink_off) ? 7'h7F : w_dec_seg_n;
            end
         end
         ST_DRIVE: begin
            if (r_cnt == LP_CNT_W'(REFRESH_DIV - 1)) begin
               w_state_nxt = ST_GUARD;
               w_cnt_nxt   = '0;
               w_idx_nxt   = (r_idx == LP_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
               w_seg_nxt   = 7'h7F;
               w_an_nxt    = '1;
            end
         end
         default: begin
            w_state_nxt = ST_GUARD;
            w_cnt_nxt   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a 4-digit and a 3-digit instance against a slot/frame arithmetic model.
// Blink checks are compiled in when SEG_BLINK_EN is defined.

module tb_seg_scan_ctrl;
   localparam int G    = 2;
   localparam int R    = 4;
   localparam int BF   = 2;
   localparam int SLOT = G + R;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_wr_valid, a_wr_ready, a_wr_blank;
   logic [1:0] a_wr_digit;
   logic [3:0] a_wr_data;
   logic [6:0] a_seg_n;
   logic [3:0] a_an_n;
   logic [3:0] a_mask;
   logic       b_wr_valid, b_wr_ready, b_wr_blank;
   logic [1:0] b_wr_digit;
   logic [3:0] b_wr_data;
   logic [6:0] b_seg_n;
   logic [2:0] b_an_n;
   logic [2:0] b_mask;

   int errors = 0;
   int checks = 0;
   int k      = 0;

   logic [3:0] a_val [4];
   logic       a_blk [4];
   logic [3:0] b_val [3];
   logic       b_blk [3];

   seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(R), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (a_wr_valid),
      .wr_ready   (a_wr_ready),
      .wr_digit   (a_wr_digit),
      .wr_data    (a_wr_data),
      .wr_blank   (a_wr_blank),
`ifdef SEG_BLINK_EN
      .blink_mask (a_mask),
`endif
      .seg_n      (a_seg_n),
      .an_n       (a_an_n)
   );

   seg_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(R), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (b_wr_valid),
      .wr_ready   (b_wr_ready),
      .wr_digit   (b_wr_digit),
      .wr_data    (b_wr_data),
      .wr_blank   (b_wr_blank),
`ifdef SEG_BLINK_EN
      .blink_mask (b_mask),
`endif
      .seg_n      (b_seg_n),
      .an_n       (b_an_n)
   );

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // kk = clock edges since reset release; each digit slot is G guard cycles then R drive cycles.
   function automatic bit in_guard(input int kk);
      return (kk % SLOT) < G;
   endfunction

   function automatic int cur_digit(input int kk, input int n);
      return (kk / SLOT) % n;
   endfunction

   function automatic bit blink_on(input int kk, input int n);
`ifdef SEG_BLINK_EN
      return (((kk / (n * SLOT)) / BF) % 2) == 1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] exp_an(input int kk, input int n);
      logic [7:0] v;
      v = 8'hFF;
      if (!in_guard(kk)) v[cur_digit(kk, n)] = 1'b0;
      return v & ((8'h01 << n) - 8'h01);
   endfunction

   function automatic logic [6:0] exp_seg(input int kk, input int n, input logic [3:0] v,
                                          input logic b, input logic m);
      if (in_guard(kk) || b || (m && blink_on(kk, n))) return 7'h7F;
      return hex7(v);
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
      end
   endtask

   task automatic check_all();
      int da, db;
      da = cur_digit(k, 4);
      db = cur_digit(k, 3);
      check("a_an_n", {4'h0, a_an_n}, exp_an(k, 4));
      check("a_seg_n", {1'b0, a_seg_n}, {1'b0, exp_seg(k, 4, a_val[da], a_blk[da], a_mask[da])});
      check("a_wr_ready", {7'h0, a_wr_ready}, {7'h0, in_guard(k)});
      check("b_an_n", {5'h0, b_an_n}, exp_an(k, 3));
      check("b_seg_n", {1'b0, b_seg_n}, {1'b0, exp_seg(k, 3, b_val[db], b_blk[db], b_mask[db])});
      check("b_wr_ready", {7'h0, b_wr_ready}, {7'h0, in_guard(k)});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin a_val[i] = 4'h0; a_blk[i] = 1'b1; end
      for (int i = 0; i < 3; i++) begin b_val[i] = 4'h0; b_blk[i] = 1'b1; end
      k = 0;
   endtask

   // One clock: record accepted writes at the edge, then move inputs and check at edge+1.
   task automatic step();
      bit g, a_acc, b_acc;
      g = in_guard(k);
      @(posedge clk);
      a_acc = a_wr_valid && g;
      b_acc = b_wr_valid && g;
      if (a_acc) begin
         a_val[a_wr_digit] = a_wr_data;
         a_blk[a_wr_digit] = a_wr_blank;
      end
      if (b_acc && (b_wr_digit < 2'd3)) begin
         b_val[b_wr_digit] = b_wr_data;
         b_blk[b_wr_digit] = b_wr_blank;
      end
      #1;
      if (a_acc) a_wr_valid = 1'b0;
      if (b_acc) b_wr_valid = 1'b0;
      k++;
      check_all();
   endtask

   task automatic write_a(input logic [1:0] d, input logic [3:0] v, input logic b);
      a_wr_valid = 1'b1; a_wr_digit = d; a_wr_data = v; a_wr_blank = b;
      for (int i = 0; i < 3 * SLOT && a_wr_valid; i++) step();
   endtask

   task automatic write_b(input logic [1:0] d, input logic [3:0] v, input logic b);
      b_wr_valid = 1'b1; b_wr_digit = d; b_wr_data = v; b_wr_blank = b;
      for (int i = 0; i < 3 * SLOT && b_wr_valid; i++) step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_until(input int pos, input int dig);
      for (int i = 0; i < 8 * SLOT && !((k % SLOT) == pos && cur_digit(k, 4) == dig); i++) step();
   endtask

   task automatic rand_inputs();
      if (!a_wr_valid && $urandom_range(0, 2) == 0) begin
         a_wr_valid = 1'b1;
         a_wr_digit = 2'($urandom_range(0, 3));
         a_wr_data  = 4'($urandom_range(0, 15));
         a_wr_blank = ($urandom_range(0, 3) == 0);
      end
      if (!b_wr_valid && $urandom_range(0, 2) == 0) begin
         b_wr_valid = 1'b1;
         b_wr_digit = 2'($urandom_range(0, 3));
         b_wr_data  = 4'($urandom_range(0, 15));
         b_wr_blank = ($urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      a_wr_valid = 1'b0; a_wr_digit = 2'd0; a_wr_data = 4'h0; a_wr_blank = 1'b0;
      b_wr_valid = 1'b0; b_wr_digit = 2'd0; b_wr_data = 4'h0; b_wr_blank = 1'b0;
      a_mask = 4'b0001;
      b_mask = 3'b010;
      model_reset();

      // Reset state, then release between edges.
      @(posedge clk); @(posedge clk); #1;
      check_all();
      #1 reset = 1'b0;
      check_all();

      // Scan order with digits 1,2,3,4 over two frames.
      write_a(2'd0, 4'h1, 1'b0);
      write_a(2'd1, 4'h2, 1'b0);
      write_a(2'd2, 4'h3, 1'b0);
      write_a(2'd3, 4'h4, 1'b0);
      run(8 * SLOT);

      // Write held across a whole drive interval.
      wait_until(G, 1);
      a_wr_valid = 1'b1; a_wr_digit = 2'd2; a_wr_data = 4'hA; a_wr_blank = 1'b0;
      run(4 * SLOT);

      // Bypass on the guard->drive edge: blank first, then shown as 8.
      wait_until(G - 1, 1);
      a_wr_valid = 1'b1; a_wr_digit = 2'd1; a_wr_data = 4'h8; a_wr_blank = 1'b1;
      run(2);
      wait_until(G - 1, 1);
      a_wr_valid = 1'b1; a_wr_digit = 2'd1; a_wr_data = 4'h8; a_wr_blank = 1'b0;
      run(2);

      // Out-of-range write on the 3-digit instance is accepted and dropped.
      write_b(2'd0, 4'h7, 1'b0);
      write_b(2'd1, 4'h8, 1'b0);
      write_b(2'd2, 4'h9, 1'b0);
      write_b(2'd3, 4'h0, 1'b1);
      run(2 * 3 * SLOT);

      // Asynchronous reset while digit 1 is driven with 5.
      write_a(2'd1, 4'h5, 1'b0);
      wait_until(G + 1, 1);
      reset = 1'b1;
      #1;
      check("rst_async_seg", {1'b0, a_seg_n}, 8'h7F);
      check("rst_async_an", {4'h0, a_an_n}, 8'h0F);
      check("rst_async_b_an", {5'h0, b_an_n}, 8'h07);
      @(posedge clk);
      #2 reset = 1'b0;
      a_wr_valid = 1'b0; b_wr_valid = 1'b0;
      model_reset();
      check_all();

      // Blink sequence on digit 0 = 3, then randomized traffic on both instances.
      write_a(2'd0, 4'h3, 1'b0);
      run(5 * 4 * SLOT);
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog k=%0d observed=timeout expected=finish", k);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
